// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Grants are combinational, the RAM command is registered one cycle after the
// grant, and read data is steered back to its owner two cycles after the grant.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic                  r_prio;        // 0 = A wins a tie, 1 = B wins a tie
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_tag1_valid;  // read issued to RAM this cycle
    logic                  r_tag1_owner;  // 0 = A, 1 = B
    logic                  r_tag2_valid;  // RAM read data present this cycle
    logic                  r_tag2_owner;

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_grant;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Grant selection: lone requester always wins, ties go to the prio pointer.
    // Grants are suppressed while reset is held so ready stays low.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst) begin
            if (a_valid && (!b_valid || !r_prio))
                w_grant_a = 1'b1;
            else if (b_valid)
                w_grant_b = 1'b1;
        end
    end

    assign w_grant     = w_grant_a | w_grant_b;
    assign w_sel_we    = w_grant_b ? b_we    : a_we;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;

    // Issue register, round-robin pointer and read-tag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio       <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_tag1_valid <= 1'b0;
            r_tag1_owner <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_owner <= 1'b0;
        end else begin
            if (w_grant_a)
                r_prio <= 1'b1;
            else if (w_grant_b)
                r_prio <= 1'b0;

            r_ram_en <= w_grant;
            r_ram_we <= w_grant & w_sel_we;
            if (w_grant) begin
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
            end

            r_tag1_valid <= w_grant & ~w_sel_we;
            r_tag1_owner <= w_grant_b;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_owner <= r_tag1_owner;
        end
    end

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

    assign a_rvalid  = r_tag2_valid & ~r_tag2_owner;
    assign b_rvalid  = r_tag2_valid &  r_tag2_owner;
    assign a_rdata   = a_rvalid ? ram_rdata : '0;
    assign b_rdata   = b_rvalid ? ram_rdata : '0;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the RAM word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, the RAM address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports a_valid / b_valid, input, 1 bit each: requester A/B presents a request.
REQ-006 The block SHALL have ports a_ready / b_ready, output, 1 bit each: the request is accepted this cycle.
REQ-007 The block SHALL have ports a_we / b_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports a_addr / b_addr, input, ADDR_WIDTH each: the request address.
REQ-009 The block SHALL have ports a_wdata / b_wdata, input, DATA_WIDTH each: the write data.
REQ-010 The block SHALL have ports a_rvalid / b_rvalid, output, 1 bit each: read data for A/B is valid.
REQ-011 The block SHALL have ports a_rdata / b_rdata, output, DATA_WIDTH each: the read data.
REQ-012 The block SHALL have port ram_en, output, 1 bit: a RAM access is issued this cycle.
REQ-013 The block SHALL have port ram_we, output, 1 bit: the RAM write enable, qualified by ram_en.
REQ-014 The block SHALL have port ram_addr, output, ADDR_WIDTH: the RAM address.
REQ-015 The block SHALL have port ram_wdata, output, DATA_WIDTH: the RAM write data.
REQ-016 The block SHALL have port ram_rdata, input, DATA_WIDTH: RAM read data, valid 1 cycle after a read is issued.

Function
REQ-017 Handshake: a request SHALL transfer in any cycle where x_valid && x_ready; x_ready SHALL be combinational from the valid inputs and the priority pointer.
REQ-018 At most one of a_ready / b_ready SHALL be high in any cycle.
REQ-019 Single requester valid: that requester SHALL be granted every cycle (no bubbles).
REQ-020 Both requesters valid: grant SHALL go to the requester named by the round-robin pointer prio (0 = A, 1 = B).
REQ-021 After each grant, prio SHALL point to the non-granted requester; prio SHALL be unchanged in cycles with no grant.
REQ-022 Issue stage: on a grant at cycle N, the block SHALL register ram_en=1 plus the granted we/addr/wdata, so they appear on the RAM ports in cycle N+1.
REQ-023 In cycles N+1 with no grant at N, ram_en and ram_we SHALL be 0, and ram_addr / ram_wdata SHALL hold their last values.
REQ-024 Read tracking: the block SHALL carry a 2-stage tag pipeline (valid, owner) alongside each read issue.
REQ-025 A read granted at cycle N SHALL return on x_rvalid for exactly one cycle at N+2, with x_rdata = ram_rdata in that cycle.
REQ-026 Writes SHALL produce no rvalid pulse.
REQ-027 When x_rvalid is low, x_rdata SHALL be 0.
REQ-028 Read returns SHALL be in grant order; with back-to-back grants, throughput SHALL be one access per cycle.
REQ-029 Same-address write at N then read at N+1: the read SHALL return the new data, relying on RAM write-before-read across cycles; the block adds no forwarding.
REQ-030 Responses SHALL have no backpressure; requesters must sink rvalid every cycle.

Reset
REQ-031 While rst=1, the block SHALL hold: a_ready=b_ready=0, ram_en=ram_we=0, ram_addr=0, ram_wdata=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, prio=0, tag pipeline cleared.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads: no rvalid pulse follows for them.
REQ-033 After reset deassertion, the first cycle SHALL allow grants.

Verification
REQ-034 The bench SHALL cover a single requester: A writes 0x5A to addr 0x0010 at cycle N, then reads it at N+1 -> ram_en/ram_we=1, ram_addr=0x0010 at N+1; a_rvalid=1 with a_rdata=0x5A at N+3; b_rvalid stays 0.
REQ-035 The bench SHALL cover contention: A and B both valid reads for 4 cycles after reset -> grants A,B,A,B; rvalids alternate A,B,A,B starting 2 cycles after the first grant.
REQ-036 The bench SHALL cover a streaming requester: B valid every cycle, A idle -> b_ready=1 every cycle; A then asserts valid -> A is granted on the next tie per prio.
REQ-037 The bench SHALL cover writes-only: 8 back-to-back writes from A -> 8 consecutive ram_en cycles; no a_rvalid / b_rvalid pulses.
REQ-038 The bench SHALL cover reset mid-read: rst asserted 1 cycle after a B read grant -> all outputs 0 immediately; no b_rvalid after release; prio=0.
REQ-039 The bench SHALL check the invariant in all scenarios: a_ready && b_ready never both 1.
